// File: rtl/snn_window_sched.sv
// Decision-window scheduler: latches one sensor sample, clears the network, runs a fixed
// window of enabled steps, counts output spikes and reports counts plus a winner code.
module snn_window_sched #(
  parameter int EXCNUM = 2,
  parameter int SENSW  = 12,
  parameter int WINDOW = 64,
  parameter int SETTLE = 2,
  parameter int CNTW   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     abort,
  input  logic                     sens_valid,
  output logic                     sens_ready,
  input  logic [4*SENSW-1:0]       sens_data,
  output logic                     snn_rst,
  output logic                     snn_en,
  output logic [4*SENSW-1:0]       snn_sensor,
  input  logic [EXCNUM-1:0]        snn_spike,
  output logic                     dec_valid,
  input  logic                     dec_ready,
  output logic [EXCNUM*CNTW-1:0]   dec_count,
  output logic [1:0]               dec_winner,
  output logic                     busy
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_RUN    = 3'd2;
  localparam logic [2:0] S_DONE   = 3'd3;
  localparam logic [2:0] S_REPORT = 3'd4;

  localparam int PMAX = (SETTLE > WINDOW) ? SETTLE : WINDOW;
  localparam int PW   = $clog2(PMAX + 1);

  logic [2:0]                   state;
  logic [2:0]                   state_nxt;
  logic [PW-1:0]                phase;
  logic                         en_d;
  logic [EXCNUM-1:0][CNTW-1:0]  cnt;
  logic [EXCNUM-1:0][CNTW-1:0]  cnt_nxt;
  logic [1:0]                   winner_nxt;
  logic                         accept;
  logic                         cancel;

  assign sens_ready = (state == S_IDLE);
  assign accept     = sens_valid & sens_ready;
  assign cancel     = abort & ((state == S_CLEAR) || (state == S_RUN) || (state == S_DONE));
  assign snn_rst    = (state == S_IDLE) || (state == S_CLEAR);
  assign snn_en     = (state == S_RUN);
  assign dec_valid  = (state == S_REPORT);
  assign busy       = (state != S_IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept) state_nxt = S_CLEAR;
      S_CLEAR:  if (phase == '0) state_nxt = S_RUN;
      S_RUN:    if (phase == '0) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_REPORT;
      S_REPORT: if (dec_ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
    if (cancel) state_nxt = S_IDLE;
  end

  // Spikes lag the enable by one cycle because the network registers them, hence en_d.
  always_comb begin
    cnt_nxt = cnt;
    for (int i = 0; i < EXCNUM; i++) begin
      if (en_d && snn_spike[i] && (cnt[i] != '1)) cnt_nxt[i] = cnt[i] + CNTW'(1);
    end
  end

  always_comb begin
    winner_nxt = 2'b11;
    if ((cnt_nxt[0] == '0) && (cnt_nxt[1] == '0)) winner_nxt = 2'b00;
    else if (cnt_nxt[0] > cnt_nxt[1])             winner_nxt = 2'b01;
    else if (cnt_nxt[1] > cnt_nxt[0])             winner_nxt = 2'b10;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      phase <= '0;
      en_d  <= 1'b0;
    end else begin
      state <= state_nxt;
      en_d  <= snn_en;
      if (accept)                                 phase <= PW'(SETTLE - 1);
      else if ((state == S_CLEAR) && (phase == '0)) phase <= PW'(WINDOW - 1);
      else if (phase != '0)                       phase <= phase - PW'(1);
    end
  end

  // The decision captures cnt_nxt so the spike arriving during DONE is included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      snn_sensor <= '0;
      dec_count  <= '0;
      dec_winner <= 2'b00;
    end else begin
      if (accept || cancel) cnt <= '0;
      else                  cnt <= cnt_nxt;
      if (accept) snn_sensor <= sens_data;
      if ((state == S_DONE) && !cancel) begin
        dec_count  <= cnt_nxt;
        dec_winner <= winner_nxt;
      end
    end
  end

endmodule

// File: tb/tb_snn_window_sched.sv
// Self-checking bench for snn_window_sched: scoreboard of expected decisions built from
// the bench's own spike pattern, plus abort, backpressure, async reset and saturation cases.
`timescale 1ns/1ps
module tb_snn_window_sched;

  localparam int SETTLE_P = 2;
  localparam int WINDOW_P = 64;
  localparam int TOT      = SETTLE_P + WINDOW_P + 2;
  localparam int SAT_WIN  = 255;

  typedef struct {
    logic [15:0] count;
    logic [1:0]  winner;
  } dec_t;

  logic        clk;
  logic        rst_n;
  logic        abort;
  logic        sens_valid;
  logic        sens_ready;
  logic [47:0] sens_data;
  logic        snn_rst;
  logic        snn_en;
  logic [47:0] snn_sensor;
  logic [1:0]  snn_spike;
  logic        dec_valid;
  logic        dec_ready;
  logic [15:0] dec_count;
  logic [1:0]  dec_winner;
  logic        busy;

  logic        sat_abort;
  logic        sat_sens_valid;
  logic        sat_sens_ready;
  logic        sat_snn_rst;
  logic        sat_snn_en;
  logic [47:0] sat_snn_sensor;
  logic [1:0]  sat_spike;
  logic        sat_dec_valid;
  logic        sat_dec_ready;
  logic [7:0]  sat_dec_count;
  logic [1:0]  sat_dec_winner;
  logic        sat_busy;

  int   checks;
  int   failures;
  dec_t sb[$];
  logic [1:0] spk [0:TOT];

  snn_window_sched #(.EXCNUM(2), .SENSW(12), .WINDOW(WINDOW_P), .SETTLE(SETTLE_P), .CNTW(8)) dut (
    .clk(clk), .rst_n(rst_n), .abort(abort), .sens_valid(sens_valid), .sens_ready(sens_ready),
    .sens_data(sens_data), .snn_rst(snn_rst), .snn_en(snn_en), .snn_sensor(snn_sensor),
    .snn_spike(snn_spike), .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_count(dec_count),
    .dec_winner(dec_winner), .busy(busy)
  );

  snn_window_sched #(.EXCNUM(2), .SENSW(12), .WINDOW(SAT_WIN), .SETTLE(SETTLE_P), .CNTW(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .abort(sat_abort), .sens_valid(sat_sens_valid), .sens_ready(sat_sens_ready),
    .sens_data(48'h0AB_123_456_789), .snn_rst(sat_snn_rst), .snn_en(sat_snn_en), .snn_sensor(sat_snn_sensor),
    .snn_spike(sat_spike), .dec_valid(sat_dec_valid), .dec_ready(sat_dec_ready), .dec_count(sat_dec_count),
    .dec_winner(sat_dec_winner), .busy(sat_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [1:0] expWinner(input int c0, input int c1);
    if (c0 == 0 && c1 == 0) return 2'b00;
    if (c0 > c1) return 2'b01;
    if (c1 > c0) return 2'b10;
    return 2'b11;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // mode 0: output 0 spikes every cycle; mode 1: output 1 in first RUN and DONE only; mode 2: random
  task automatic applyStimulus(input logic [47:0] data, input int mode, input int hold,
                               input bit abort_run, input bit abort_accept);
    int c0, c1;
    dec_t item;
    c0 = 0;
    c1 = 0;
    for (int k = 0; k <= TOT; k++) begin
      case (mode)
        0:       spk[k] = 2'b01;
        1:       spk[k] = (k == SETTLE_P + 1 || k == SETTLE_P + WINDOW_P + 1) ? 2'b10 : 2'b00;
        default: spk[k] = 2'($urandom_range(0, 3));
      endcase
      if (k >= SETTLE_P + 2 && k <= SETTLE_P + WINDOW_P + 1) begin
        c0 += int'(spk[k][0]);
        c1 += int'(spk[k][1]);
      end
    end
    if (c0 > 255) c0 = 255;
    if (c1 > 255) c1 = 255;
    item.count  = {c1[7:0], c0[7:0]};
    item.winner = expWinner(c0, c1);
    if (!abort_run) sb.push_back(item);

    sens_valid = 1'b1;
    sens_data  = data;
    abort      = abort_accept;
    dec_ready  = (hold == 0);
    snn_spike  = 2'b11;
    checkOutput("sens_ready_idle", sens_ready, 1);
    step();
    sens_valid = 1'b0;
    abort      = 1'b0;
    for (int k = 1; k <= SETTLE_P + WINDOW_P + 1; k++) begin
      snn_spike = spk[k];
      checkOutput("snn_en", snn_en, (k >= SETTLE_P + 1 && k <= SETTLE_P + WINDOW_P));
      checkOutput("snn_rst", snn_rst, (k <= SETTLE_P));
      checkOutput("dec_valid_early", dec_valid, 0);
      if (k == 1) begin
        checkOutput("snn_sensor", snn_sensor, data);
        checkOutput("busy_run", busy, 1);
        checkOutput("sens_ready_busy", sens_ready, 0);
      end
      if (abort_run && k == SETTLE_P + 10) begin
        abort = 1'b1;
        step();
        abort = 1'b0;
        checkOutput("abort_snn_en", snn_en, 0);
        checkOutput("abort_snn_rst", snn_rst, 1);
        checkOutput("abort_sens_ready", sens_ready, 1);
        checkOutput("abort_snn_sensor", snn_sensor, data);
        for (int j = 0; j < 8; j++) begin
          snn_spike = 2'($urandom_range(0, 3));
          checkOutput("abort_no_valid", dec_valid, 0);
          step();
        end
        return;
      end
      step();
    end

    for (int h = 0; h < hold; h++) begin
      checkOutput("bp_dec_valid", dec_valid, 1);
      checkOutput("bp_sens_ready", sens_ready, 0);
      checkOutput("bp_dec_count", dec_count, sb[0].count);
      checkOutput("bp_dec_winner", dec_winner, sb[0].winner);
      snn_spike  = 2'($urandom_range(0, 3));
      sens_valid = 1'($urandom_range(0, 1));
      step();
    end
    sens_valid = 1'b0;
    dec_ready  = 1'b1;
    item = sb.pop_front();
    checkOutput("dec_valid", dec_valid, 1);
    checkOutput("dec_count", dec_count, item.count);
    checkOutput("dec_winner", dec_winner, item.winner);
    step();
    dec_ready = 1'b0;
    checkOutput("post_sens_ready", sens_ready, 1);
    checkOutput("post_dec_valid", dec_valid, 0);
    checkOutput("post_busy", busy, 0);
  endtask

  task automatic asyncResetMidRun(input logic [47:0] data);
    sens_valid = 1'b1;
    sens_data  = data;
    step();
    sens_valid = 1'b0;
    repeat (SETTLE_P + 5) step();
    checkOutput("ar_pre_en", snn_en, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("ar_snn_en", snn_en, 0);
    checkOutput("ar_snn_rst", snn_rst, 1);
    checkOutput("ar_sens_ready", sens_ready, 1);
    checkOutput("ar_busy", busy, 0);
    checkOutput("ar_snn_sensor", snn_sensor, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checkOutput("ar_release_ready", sens_ready, 1);
    checkOutput("ar_release_en", snn_en, 0);
    checkOutput("ar_release_count", dec_count, 0);
  endtask

  task automatic saturationRun();
    int lat;
    lat = 0;
    sat_spike      = 2'b11;
    sat_dec_ready  = 1'b1;
    sat_sens_valid = 1'b1;
    step();
    sat_sens_valid = 1'b0;
    while (lat < 400 && !sat_dec_valid) begin
      lat++;
      step();
    end
    checkOutput("sat_latency", lat, SETTLE_P + SAT_WIN + 1);
    checkOutput("sat_dec_count", sat_dec_count, 8'hFF);
    checkOutput("sat_dec_winner", sat_dec_winner, 2'b11);
    step();
    checkOutput("sat_sens_ready", sat_sens_ready, 1);
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    rst_n          = 1'b0;
    abort          = 1'b0;
    sens_valid     = 1'b0;
    sens_data      = '0;
    snn_spike      = 2'b00;
    dec_ready      = 1'b0;
    sat_abort      = 1'b0;
    sat_sens_valid = 1'b0;
    sat_spike      = 2'b00;
    sat_dec_ready  = 1'b0;
    #12;
    checkOutput("rst_sens_ready", sens_ready, 1);
    checkOutput("rst_snn_rst", snn_rst, 1);
    checkOutput("rst_snn_en", snn_en, 0);
    checkOutput("rst_snn_sensor", snn_sensor, 0);
    checkOutput("rst_dec_valid", dec_valid, 0);
    checkOutput("rst_dec_count", dec_count, 0);
    checkOutput("rst_dec_winner", dec_winner, 0);
    checkOutput("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) step();

    applyStimulus({12'd150, 12'd750, 12'd750, 12'd150}, 0, 0, 1'b0, 1'b0);
    applyStimulus(48'h123_456_789_ABC, 1, 0, 1'b0, 1'b0);
    applyStimulus(48'hFED_CBA_987_654, 2, 20, 1'b0, 1'b0);
    applyStimulus(48'h111_222_333_444, 0, 0, 1'b1, 1'b0);
    applyStimulus(48'h555_666_777_888, 0, 2, 1'b0, 1'b0);
    applyStimulus(48'hA5A_5A5_0F0_F0F, 2, 0, 1'b0, 1'b1);
    asyncResetMidRun(48'h999_AAA_BBB_CCC);
    applyStimulus(48'h0C0_0FF_EE0_123, 2, 1, 1'b0, 1'b0);
    saturationRun();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
